// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the 800x600@60 Hz raster timing generator.
// The 800x600 geometry lives here so the renderer and the HDMI encoder can
// agree with the timing generator. The generator also exposes the geometry
// as parameters so that smaller rasters can be built from the same source.
package vga_pkg;

  // Horizontal geometry in pixels (40 MHz pixel clock).
  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FP      = 40;
  localparam int DEF_H_SYNC    = 128;
  localparam int DEF_H_BP      = 88;

  // Vertical geometry in lines.
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FP      = 1;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BP      = 23;

  // Both syncs are active-high for this mode.
  localparam bit DEF_HSYNC_POL = 1'b1;
  localparam bit DEF_VSYNC_POL = 1'b1;

  // Synchronized lock must hold this many cycles before the raster starts.
  localparam int DEF_LOCK_HOLD = 16;

  // Derived totals: 1056 pixels per line and 628 lines per frame.
  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Raster coordinates are 11 bits wide; both totals fit below 2^11.
  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  // Raster is either waiting for a stable clock or producing a frame.
  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } timing_state_t;

  // True when lo <= v < hi_excl; used for the sync windows.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi_excl);
    return (v >= lo) && (v < hi_excl);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by the timing generator and consumed by the
// renderer and the HDMI encoder. All signals are registered in the pixel
// clock domain and describe the same pixel position in every cycle.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   running;
  coord_t col;
  coord_t row;
  logic   hsync;
  logic   vsync;
  logic   blank;
  logic   line_start;
  logic   frame_start;

  // Timing generator side.
  modport master (
    output running,
    output col,
    output row,
    output hsync,
    output vsync,
    output blank,
    output line_start,
    output frame_start
  );

  // Consumer side (renderer, HDMI encoder).
  modport slave (
    input running,
    input col,
    input row,
    input hsync,
    input vsync,
    input blank,
    input line_start,
    input frame_start
  );

endinterface

// File: rtl/vga_timing_gen_sync_2ff.sv
// Generic two-flop synchronizer for a single slow-changing bit that arrives
// from another clock domain. Both stages reset to RESET_VAL so the output
// is well defined while reset is held.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-domain raster timing generator. Waits for the clock generator lock
// to be stable, then walks col/row over the full raster and produces syncs,
// blanking and line/frame strobes. Every output is registered from the same
// next-position value, so all of them describe the (col,row) shown in the
// same cycle with no skew between them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = DEF_HSYNC_POL,
  parameter bit VSYNC_POL = DEF_VSYNC_POL,
  parameter int LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Terminal counts and decode boundaries in coordinate width.
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_STOP  = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_STOP  = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  // Inactive sync levels, also the idle/reset levels.
  localparam bit HS_IDLE = ~HSYNC_POL;
  localparam bit VS_IDLE = ~VSYNC_POL;

  // hold_cnt counts 0..LOCK_HOLD-1; the edge that would take it to
  // LOCK_HOLD is the edge that starts the raster.
  localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

  logic lock_s;

  timing_state_t     state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  coord_t            col_q, row_q, col_next, row_next;

  logic running_q, hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;
  logic running_d, hsync_d, vsync_d, blank_d, line_start_d, frame_start_d;

  // The lock indicator comes from the clock generator and is asynchronous.
  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (lock_s)
  );

  // State, counters and decoded outputs all update together on each edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= WAIT_LOCK;
      hold_cnt      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      running_q     <= 1'b0;
      hsync_q       <= HS_IDLE;
      vsync_q       <= VS_IDLE;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      col_q         <= col_next;
      row_q         <= row_next;
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Lock qualification, raster walk and fall-back to idle on lost lock.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    col_next   = col_q;
    row_next   = row_q;
    case (state)
      WAIT_LOCK: begin
        col_next = '0;
        row_next = '0;
        if (!lock_s) begin
          hold_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = RUN;
          hold_next  = '0;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        hold_next = '0;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          col_next   = '0;
          row_next   = '0;
        end else if (col_q == H_LAST) begin
          col_next = '0;
          row_next = (row_q == V_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_next = col_q + 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        hold_next  = '0;
        col_next   = '0;
        row_next   = '0;
      end
    endcase
  end

  // Decode the position about to be shown so the registers stay aligned.
  always_comb begin
    running_d     = 1'b0;
    hsync_d       = HS_IDLE;
    vsync_d       = VS_IDLE;
    blank_d       = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (state_next == RUN) begin
      running_d     = 1'b1;
      hsync_d       = in_window(col_next, HS_START, HS_STOP) ? HSYNC_POL : HS_IDLE;
      vsync_d       = in_window(row_next, VS_START, VS_STOP) ? VSYNC_POL : VS_IDLE;
      blank_d       = (col_next >= H_VIS) || (row_next >= V_VIS);
      line_start_d  = (col_next == '0);
      frame_start_d = (col_next == '0) && (row_next == '0);
    end
  end

  assign vid.running     = running_q;
  assign vid.col         = col_q;
  assign vid.row         = row_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.blank       = blank_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A full 800x600 instance covers lock timing and
// line-level behaviour; a small-raster instance with active-low syncs shares
// the same clock, reset and lock so frame-level behaviour fits a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        running;
    logic [10:0] col;
    logic [10:0] row;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        line_start;
    logic        frame_start;
  } obs_t;

  logic clock;
  logic reset;
  logic locked;

  int tests_run;
  int tests_failed;
  int run_t;

  obs_t q_full[$];
  obs_t q_small[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vga_timing_gen_if vid_full();
  vga_timing_gen_if vid_small();

  vga_timing_gen u_full (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .vid    (vid_full)
  );

  // 32 pixels x 18 lines, syncs at col 20..27 and rows 13..15, active low.
  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VISIBLE (12), .V_FP (1), .V_SYNC (3), .V_BP (2),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .LOCK_HOLD (16)
  ) u_small (
    .clock  (clock),
    .reset  (reset),
    .locked (locked),
    .vid    (vid_small)
  );

  // Expected outputs t cycles after the first running cycle.
  function automatic obs_t model_run(int t, int hv, int hfp, int hs, int hbp,
                                     int vv, int vfp, int vs, int vbp,
                                     bit hp, bit vp);
    obs_t o;
    int ht;
    int vt;
    int c;
    int r;
    ht = hv + hfp + hs + hbp;
    vt = vv + vfp + vs + vbp;
    c  = t % ht;
    r  = (t / ht) % vt;
    o.running     = 1'b1;
    o.col         = 11'(c);
    o.row         = 11'(r);
    o.hsync       = (c >= hv + hfp && c < hv + hfp + hs) ? hp : ~hp;
    o.vsync       = (r >= vv + vfp && r < vv + vfp + vs) ? vp : ~vp;
    o.blank       = (c >= hv) || (r >= vv);
    o.line_start  = (c == 0);
    o.frame_start = (c == 0) && (r == 0);
    return o;
  endfunction

  function automatic obs_t idle_obs(bit hp, bit vp);
    obs_t o;
    o       = '0;
    o.hsync = ~hp;
    o.vsync = ~vp;
    o.blank = 1'b1;
    return o;
  endfunction

  function automatic obs_t exp_full(int t);
    return model_run(t, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
  endfunction

  function automatic obs_t exp_small(int t);
    return model_run(t, 16, 4, 8, 4, 12, 1, 3, 2, 1'b0, 1'b0);
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++) begin
      q_full.push_back(idle_obs(1'b1, 1'b1));
      q_small.push_back(idle_obs(1'b0, 1'b0));
    end
  endfunction

  function automatic void push_run(int first, int last);
    for (int t = first; t <= last; t++) begin
      q_full.push_back(exp_full(t));
      q_small.push_back(exp_small(t));
    end
  endfunction

  function automatic obs_t sample_full();
    obs_t o;
    o.running     = vid_full.running;
    o.col         = vid_full.col;
    o.row         = vid_full.row;
    o.hsync       = vid_full.hsync;
    o.vsync       = vid_full.vsync;
    o.blank       = vid_full.blank;
    o.line_start  = vid_full.line_start;
    o.frame_start = vid_full.frame_start;
    return o;
  endfunction

  function automatic obs_t sample_small();
    obs_t o;
    o.running     = vid_small.running;
    o.col         = vid_small.col;
    o.row         = vid_small.row;
    o.hsync       = vid_small.hsync;
    o.vsync       = vid_small.vsync;
    o.blank       = vid_small.blank;
    o.line_start  = vid_small.line_start;
    o.frame_start = vid_small.frame_start;
    return o;
  endfunction

  task automatic test_reset();
    obs_t ef, es, of, os;
    reset  = 1'b1;
    locked = 1'b1;
    @(negedge clock);
    push_idle(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL reset_full i=%0d got=%h exp=%h", i, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL reset_small i=%0d got=%h exp=%h", i, os, es); end
    end
  endtask

  task automatic test_lock_timing();
    obs_t ef, es, of, os;
    push_idle(17);
    push_run(0, 39);
    reset = 1'b0;
    for (int i = 0; i < 57; i++) begin
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL lock_timing_full i=%0d got=%h exp=%h", i, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL lock_timing_small i=%0d got=%h exp=%h", i, os, es); end
    end
    run_t = 39;
  endtask

  task automatic test_full_line();
    obs_t ef, es, of, os;
    int t;
    int hs_cnt, bl_cnt, ls_cnt, ls_prev, first_blank;
    hs_cnt = 0; bl_cnt = 0; ls_cnt = 0; ls_prev = -1; first_blank = -1;
    push_run(run_t + 1, 2121);
    for (int i = 0; i < 2121 - run_t; i++) begin
      t = run_t + 1 + i;
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL line_full t=%0d got=%h exp=%h", t, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL line_small t=%0d got=%h exp=%h", t, os, es); end
      if (t >= 1056 && t < 2112) begin
        if (of.hsync) hs_cnt++;
        if (of.blank) bl_cnt++;
        if (of.blank && first_blank < 0) first_blank = t - 1056;
      end
      if (of.line_start) begin
        ls_cnt++;
        if (ls_prev >= 0) begin
          tests_run++;
          if (t - ls_prev != 1056) begin tests_failed++; $display("[TB] FAIL line_period got=%0d exp=1056", t - ls_prev); end
        end
        ls_prev = t;
      end
    end
    tests_run++;
    if (hs_cnt != 128) begin tests_failed++; $display("[TB] FAIL hsync_width got=%0d exp=128", hs_cnt); end
    tests_run++;
    if (bl_cnt != 256) begin tests_failed++; $display("[TB] FAIL hblank_width got=%0d exp=256", bl_cnt); end
    tests_run++;
    if (first_blank != 800) begin tests_failed++; $display("[TB] FAIL blank_start_col got=%0d exp=800", first_blank); end
    tests_run++;
    if (ls_cnt != 2) begin tests_failed++; $display("[TB] FAIL line_start_count got=%0d exp=2", ls_cnt); end
    run_t = 2121;
  endtask

  task automatic test_small_frames();
    obs_t ef, es, of, os;
    int t;
    int fs_cnt, fs_prev, vs_cnt, row_max;
    fs_cnt = 0; fs_prev = -1; vs_cnt = 0; row_max = 0;
    push_run(run_t + 1, 3460);
    for (int i = 0; i < 3460 - run_t; i++) begin
      t = run_t + 1 + i;
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL frames_full t=%0d got=%h exp=%h", t, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL frames_small t=%0d got=%h exp=%h", t, os, es); end
      if (t >= 2304 && t < 2880 && os.vsync == 1'b0) vs_cnt++;
      if (int'(os.row) > row_max) row_max = int'(os.row);
      if (os.frame_start) begin
        fs_cnt++;
        if (fs_prev >= 0) begin
          tests_run++;
          if (t - fs_prev != 576) begin tests_failed++; $display("[TB] FAIL frame_period got=%0d exp=576", t - fs_prev); end
        end
        fs_prev = t;
      end
    end
    tests_run++;
    if (fs_cnt != 3) begin tests_failed++; $display("[TB] FAIL frame_start_count got=%0d exp=3", fs_cnt); end
    tests_run++;
    if (vs_cnt != 96) begin tests_failed++; $display("[TB] FAIL vsync_width got=%0d exp=96", vs_cnt); end
    tests_run++;
    if (row_max != 17) begin tests_failed++; $display("[TB] FAIL row_max got=%0d exp=17", row_max); end
    run_t = 3460;
  endtask

  task automatic test_lock_loss();
    obs_t ef, es, of, os;
    int target, n1, total;
    target = run_t + 1;
    while (target % 576 != 202) target++;
    n1 = target - run_t;
    push_run(run_t + 1, target + 2);
    push_idle(37);
    push_run(0, 39);
    total = n1 + 2 + 37 + 40;
    for (int i = 0; i < total; i++) begin
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL lock_loss_full i=%0d got=%h exp=%h", i, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL lock_loss_small i=%0d got=%h exp=%h", i, os, es); end
      if (i == n1 - 1) locked = 1'b0;
      if (i == n1 + 21) locked = 1'b1;
    end
    run_t = 39;
  endtask

  task automatic test_glitch();
    obs_t ef, es, of, os;
    push_run(run_t + 1, run_t + 2);
    push_idle(38);
    push_run(0, 39);
    locked = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL glitch_full i=%0d got=%h exp=%h", i, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL glitch_small i=%0d got=%h exp=%h", i, os, es); end
      if (i == 11) locked = 1'b1;
      if (i == 21) locked = 1'b0;
      if (i == 22) locked = 1'b1;
    end
    run_t = 39;
  endtask

  task automatic test_reset_mid();
    obs_t ef, es, of, os;
    int n1;
    n1 = 470 - run_t;
    push_run(run_t + 1, 470);
    push_idle(21);
    push_run(0, 5);
    for (int i = 0; i < n1 + 27; i++) begin
      @(negedge clock);
      ef = q_full.pop_front();
      es = q_small.pop_front();
      of = sample_full();
      os = sample_small();
      tests_run++;
      if (of !== ef) begin tests_failed++; $display("[TB] FAIL reset_mid_full i=%0d got=%h exp=%h", i, of, ef); end
      tests_run++;
      if (os !== es) begin tests_failed++; $display("[TB] FAIL reset_mid_small i=%0d got=%h exp=%h", i, os, es); end
      if (i == n1 - 1) reset = 1'b1;
      if (i == n1 + 3) reset = 1'b0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    run_t        = 0;
    reset        = 1'b1;
    locked       = 1'b0;
    test_reset();
    test_lock_timing();
    test_full_line();
    test_small_frames();
    test_lock_loss();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
